// File: rtl/qr_payload_packer.sv
// Serial QR data-codeword parser: captures the mode indicator and character count,
// then packs byte-mode payload bytes MSB-first into five 32-bit output words.
module qr_payload_packer #(
  parameter int         MAX_BYTES = 20,
  parameter logic [3:0] BYTE_MODE = 4'b0100
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        start_in,
  input  logic        bit_in,
  input  logic        bit_valid_in,
  output logic        ready_out,
  output logic [31:0] block1_out,
  output logic [31:0] block2_out,
  output logic [31:0] block3_out,
  output logic [31:0] block4_out,
  output logic [31:0] block5_out,
  output logic [3:0]  datatype_out,
  output logic [7:0]  length_out,
  output logic        done_out,
  output logic        error_out,
  output logic        busy_out
);

  typedef enum logic [2:0] {
    IDLE,
    MODE,
    COUNT,
    DATA,
    FINISH
  } state_t;

  state_t         state_q, state_d;
  logic [2:0]     bit_cnt_q, bit_cnt_d;
  logic [4:0]     byte_idx_q, byte_idx_d;
  logic [6:0]     shift_q, shift_d;
  logic [159:0]   payload_q, payload_d;
  logic [3:0]     datatype_q, datatype_d;
  logic [7:0]     length_q, length_d;
  logic           error_q, error_d;

  logic           ready;
  logic           accept;
  logic [3:0]     mode_next;
  logic [7:0]     len_next;
  logic [7:0]     byte_next;

  assign ready     = (state_q == MODE) || (state_q == COUNT) || (state_q == DATA);
  assign accept    = bit_valid_in && ready;
  assign mode_next = {datatype_q[2:0], bit_in};
  assign len_next  = {length_q[6:0], bit_in};
  assign byte_next = {shift_q, bit_in};

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    byte_idx_d = byte_idx_q;
    shift_d    = shift_q;
    payload_d  = payload_q;
    datatype_d = datatype_q;
    length_d   = length_q;
    error_d    = error_q;

    // start_in overrides everything, including a bit accepted on the same edge
    if (start_in) begin
      state_d    = MODE;
      bit_cnt_d  = 3'd0;
      byte_idx_d = 5'd0;
      shift_d    = 7'd0;
      payload_d  = '0;
      datatype_d = 4'd0;
      length_d   = 8'd0;
      error_d    = 1'b0;
    end else begin
      case (state_q)
        IDLE: ;
        MODE: begin
          if (accept) begin
            datatype_d = mode_next;
            bit_cnt_d  = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd3) begin
              bit_cnt_d = 3'd0;
              if (mode_next == BYTE_MODE) begin
                state_d = COUNT;
              end else begin
                state_d = IDLE;
                error_d = 1'b1;
              end
            end
          end
        end
        COUNT: begin
          if (accept) begin
            length_d  = len_next;
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              bit_cnt_d  = 3'd0;
              byte_idx_d = 5'd0;
              if (len_next == 8'd0) begin
                state_d = FINISH;
              end else if (len_next > 8'(MAX_BYTES)) begin
                state_d = IDLE;
                error_d = 1'b1;
              end else begin
                state_d = DATA;
              end
            end
          end
        end
        DATA: begin
          if (accept) begin
            shift_d   = byte_next[6:0];
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              // byte k occupies bits [159-8k -: 8], i.e. block(k/4+1) from the top byte down
              for (int k = 0; k < MAX_BYTES; k++) begin
                if (byte_idx_q == 5'(k)) begin
                  payload_d[159-8*k -: 8] = byte_next;
                end
              end
              if ({3'd0, byte_idx_q} == length_q - 8'd1) begin
                state_d = FINISH;
              end else begin
                byte_idx_d = byte_idx_q + 5'd1;
              end
            end
          end
        end
        FINISH: state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q    <= IDLE;
      bit_cnt_q  <= 3'd0;
      byte_idx_q <= 5'd0;
      shift_q    <= 7'd0;
      payload_q  <= '0;
      datatype_q <= 4'd0;
      length_q   <= 8'd0;
      error_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      byte_idx_q <= byte_idx_d;
      shift_q    <= shift_d;
      payload_q  <= payload_d;
      datatype_q <= datatype_d;
      length_q   <= length_d;
      error_q    <= error_d;
    end
  end

  assign ready_out    = ready;
  assign busy_out     = (state_q != IDLE);
  assign done_out     = (state_q == FINISH);
  assign error_out    = error_q;
  assign datatype_out = datatype_q;
  assign length_out   = length_q;
  assign block1_out   = payload_q[159:128];
  assign block2_out   = payload_q[127:96];
  assign block3_out   = payload_q[95:64];
  assign block4_out   = payload_q[63:32];
  assign block5_out   = payload_q[31:0];

endmodule

// File: doc/qr_payload_packer.md
Name: qr_payload_packer

Overview:
- Parses the serial, de-interleaved, error-corrected data-codeword bitstream of a decoded QR symbol.
- Extracts the 4-bit mode indicator and the 8-bit character count, then packs up to MAX_BYTES byte-mode payload bytes into five 32-bit words.
- Sits directly upstream of the UART debug/readout core, which samples the outputs as block1..block5, datatype and length.
- Outputs are registered and hold stable between frames, so the readout core can snapshot them at any time.

Parameters:
- MAX_BYTES, 20: payload bytes stored; must be ≤ 20 (five 32-bit words).
- BYTE_MODE, 4'b0100: mode indicator value accepted as a valid payload.

Ports:
- clk_in, input, 1: system clock.
- rst_in, input, 1: synchronous active-high reset.
- start_in, input, 1: one-cycle pulse that begins a new frame; clears all payload outputs.
- bit_in, input, 1: stream bit, MSB-first within each field.
- bit_valid_in, input, 1: bit_in is valid this cycle.
- ready_out, output, 1: block consumes bit_in when bit_valid_in && ready_out.
- block1_out..block5_out, output, 32 each: packed payload bytes.
- datatype_out, output, 4: captured mode indicator.
- length_out, output, 8: captured character count.
- done_out, output, 1: one-cycle pulse when a frame completes successfully.
- error_out, output, 1: level; set on a bad mode or oversize length, cleared by start_in.
- busy_out, output, 1: high in any state other than IDLE.

Behaviour:
- Reset (rst_in sampled high at a clock edge):
  - state = IDLE.
  - All block*_out, datatype_out and length_out = 0.
  - done_out = 0, error_out = 0, busy_out = 0, ready_out = 0.
  - Internal bit counter and byte index = 0.
  - Reset has priority over every other input, including a frame in progress.
- States: IDLE, MODE, COUNT, DATA, FINISH.
- ready_out = 1 only in MODE, COUNT and DATA.
- In IDLE, bits are ignored.
- A bit is accepted only on a cycle where bit_valid_in && ready_out; there is no backpressure from downstream.
- IDLE → MODE on start_in.
  - Same edge: block*_out, datatype_out and length_out are cleared to 0; error_out is cleared.
- start_in in MODE, COUNT, DATA or FINISH aborts the current frame and behaves exactly as start_in in IDLE.
  - Outputs are cleared and the next state is MODE.
  - No done_out is generated for the aborted frame.
  - If start_in and an accepted bit coincide, start_in wins and the bit is dropped.
- MODE: shift in 4 accepted bits, MSB first, into datatype_out.
  - On the 4th bit, if the value equals BYTE_MODE, go to COUNT.
  - Otherwise set error_out = 1 and go to IDLE; datatype_out keeps the bad value.
- COUNT: shift in 8 bits, MSB first, into length_out.
  - On the 8th bit, if the value is 0, go to FINISH.
  - If it exceeds MAX_BYTES, set error_out = 1 and go to IDLE; length_out keeps the value.
  - Otherwise go to DATA with byte index k = 0.
- DATA: assemble each byte MSB first.
  - Byte k is written to block((k/4)+1)_out bits [31-8*(k%4) : 24-8*(k%4)]. Byte 0 lands in block1_out[31:24]; byte 19 lands in block5_out[7:0].
  - The write happens on the edge that accepts the byte's 8th bit. Partial bytes are never visible on the outputs.
  - After byte length_out-1 is written, go to FINISH.
- FINISH: done_out = 1 for exactly one cycle, then IDLE.
  - Outputs hold until the next start_in or reset.
  - Latency: done_out is high the cycle after the edge that accepts the final bit.
- Unused byte slots remain 0.
- Bits arriving after the frame completes (in IDLE) are ignored.
- Gaps in bit_valid_in of any length are tolerated in every state; there is no timeout.

Test Plan:
- Reset, start_in, then bits 0100, 00000011, 0x41, 0x42, 0x43 → block1_out = 0x41424300; block2..5_out = 0; datatype_out = 4; length_out = 3; done_out pulses once, 1 cycle after the last bit; error_out = 0.
- Length 20, bytes 0x00..0x13 with random bit_valid_in gaps → block1_out = 0x00010203, block5_out = 0x10111213; exactly one done_out.
- Mode 0010 (alphanumeric) → error_out = 1 after the 4th bit, datatype_out = 2, ready_out = 0, no done_out; following bits ignored.
- Byte mode, length 21 → error_out = 1, length_out = 21, all blocks = 0, no done_out.
- start_in asserted mid-DATA after 2 of 5 bytes, then a full 1-byte frame 0x5A → outputs cleared on start_in; final block1_out = 0x5A000000, length_out = 1; single done_out.
- rst_in asserted mid-COUNT → all outputs 0 the next cycle, busy_out = 0; bits ignored until start_in.
